// File: rtl/mem_requester.sv
// Single-outstanding memory requester: valid/ready handshake with release phase.
// Optional wait-state timeout is compiled in when MEM_REQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps

module mem_requester #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [DATA_BITS-1:0] resp_rdata,
  output logic                 resp_error,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  output logic                 mem_write_valid,
  output logic [ADDR_BITS-1:0] mem_write_address,
  output logic [DATA_BITS-1:0] mem_write_data,
  input  logic                 mem_write_ready
);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RELEASE,
    DONE
  } state_t;

  state_t state;
  logic   write_q;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt;
  logic          err_q;
`else
  assign resp_error = 1'b0;
`endif

  // Release waits on the ready of whichever channel was used.
  logic rel_ready;
  always_comb begin
    rel_ready = write_q ? mem_write_ready : mem_read_ready;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      write_q           <= 1'b0;
      req_ready         <= 1'b1;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      resp_error        <= 1'b0;
      tcnt              <= '0;
      err_q             <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          resp_valid <= 1'b0;
          if (req_valid) begin
            write_q   <= req_write;
            req_ready <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
            tcnt      <= '0;
            err_q     <= 1'b0;
`endif
            if (req_write) begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= req_addr;
              mem_write_data    <= req_wdata;
              state             <= WRITE_WAIT;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= req_addr;
              state            <= READ_WAIT;
            end
          end
        end

        READ_WAIT: begin
          if (mem_read_ready) begin
            resp_rdata     <= mem_read_data;
            mem_read_valid <= 1'b0;
            state          <= RELEASE;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (tcnt == TLIM) begin
            resp_rdata     <= '0;
            mem_read_valid <= 1'b0;
            err_q          <= 1'b1;
            state          <= RELEASE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end

        WRITE_WAIT: begin
          if (mem_write_ready) begin
            mem_write_valid <= 1'b0;
            state           <= RELEASE;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (tcnt == TLIM) begin
            resp_rdata      <= '0;
            mem_write_valid <= 1'b0;
            err_q           <= 1'b1;
            state           <= RELEASE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end

        RELEASE: begin
          if (!rel_ready) begin
            resp_valid <= 1'b1;
`ifdef MEM_REQ_TIMEOUT_EN
            resp_error <= err_q;
`endif
            state      <= DONE;
          end
        end

        DONE: begin
          resp_valid <= 1'b0;
`ifdef MEM_REQ_TIMEOUT_EN
          resp_error <= 1'b0;
`endif
          req_ready  <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state           <= IDLE;
          req_ready       <= 1'b1;
          resp_valid      <= 1'b0;
          mem_read_valid  <= 1'b0;
          mem_write_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_requester.sv
// Directed bench for mem_requester: scoreboard of expected responses plus a
// configurable memory responder (ack delay, ready hold, never-ack).
`timescale 1ns/1ps

module tb_mem_requester;

  localparam int unsigned AB = 8;
  localparam int unsigned DB = 16;
`ifdef MEM_REQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_write;
  logic [AB-1:0] req_addr;
  logic [DB-1:0] req_wdata;
  logic          req_ready;
  logic          resp_valid;
  logic [DB-1:0] resp_rdata;
  logic          resp_error;
  logic          mem_read_valid;
  logic [AB-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DB-1:0] mem_read_data;
  logic          mem_write_valid;
  logic [AB-1:0] mem_write_address;
  logic [DB-1:0] mem_write_data;
  logic          mem_write_ready;

  always #5 clk = ~clk;

  mem_requester #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_ready(req_ready),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_error(resp_error),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid),
    .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data),
    .mem_write_ready(mem_write_ready)
  );

  function automatic logic [DB-1:0] pat(input logic [AB-1:0] a);
    return (a == 8'h2A) ? 16'hBEEF : {a, ~a};
  endfunction

  // ---------------- memory responder ----------------
  int          delay = 0;
  int          hold = 0;
  bit          never = 1'b0;
  int          vcnt = 0;
  int          hold_left = 0;
  logic        last_w = 1'b0;
  logic [DB-1:0] mem [256];
  bit          wr [256];
  logic        vany, cur_w, ack;

  assign vany  = mem_read_valid || mem_write_valid;
  assign cur_w = vany ? mem_write_valid : last_w;
  assign ack   = !never && ((vany && vcnt >= delay) || hold_left > 0);
  assign mem_read_ready  = ack && !cur_w;
  assign mem_write_ready = ack && cur_w;
  assign mem_read_data   = wr[mem_read_address] ? mem[mem_read_address] : pat(mem_read_address);

  always @(posedge clk) begin
    if (vany) begin
      vcnt   <= vcnt + 1;
      last_w <= mem_write_valid;
      if (ack) hold_left <= hold;
      if (mem_write_valid && mem_write_ready) begin
        mem[mem_write_address] <= mem_write_data;
        wr[mem_write_address]  <= 1'b1;
      end
    end else begin
      vcnt <= 0;
      if (hold_left > 0) hold_left <= hold_left - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard and checks ----------------
  typedef struct {
    logic          write;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    logic [DB-1:0] rdata;
    logic          err;
    int            acc;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [DB-1:0] exp_mem [256];
  bit            exp_wr [256];
  logic [DB-1:0] last_rdata = '0;
  int            exp_lat = 0;
  int            tests = 0;
  int            fails = 0;
  bit            accepted;
  logic          prev_resp = 1'b0;
  logic          prev_v = 1'b0;
  int            vrun = 0;
  int            last_vrun = 0;
  int            gap = 0;
  int            last_gap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    chk("single_outstanding", sb.size(), 0);
    e.write = req_write;
    e.addr  = req_addr;
    e.wdata = req_wdata;
    e.acc   = cyc;
    e.lat   = exp_lat;
    e.err   = never;
    if (never) begin
      e.rdata    = '0;
      last_rdata = '0;
    end else if (!req_write) begin
      e.rdata    = exp_wr[req_addr] ? exp_mem[req_addr] : pat(req_addr);
      last_rdata = e.rdata;
    end else begin
      e.rdata           = last_rdata;
      exp_mem[req_addr] = req_wdata;
      exp_wr[req_addr]  = 1'b1;
    end
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    if (reset) begin
      prev_resp = 1'b0; prev_v = 1'b0; vrun = 0; gap = 0;
      return;
    end
    chk("valid_exclusive", {31'd0, mem_read_valid && mem_write_valid}, 0);
    if (vany) begin
      chk("ready_low_in_wait", {31'd0, req_ready}, 0);
      chk("wait_has_request", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        chk("wait_dir", {31'd0, mem_write_valid}, {31'd0, sb[0].write});
        if (sb[0].write) begin
          chk("wr_addr", {24'd0, mem_write_address}, {24'd0, sb[0].addr});
          chk("wr_data", {16'd0, mem_write_data}, {16'd0, sb[0].wdata});
        end else begin
          chk("rd_addr", {24'd0, mem_read_address}, {24'd0, sb[0].addr});
        end
      end
      vrun++;
      gap = 0;
    end else begin
      if (prev_v) begin
        last_vrun = vrun;
        vrun = 0;
      end
      if (!resp_valid && !req_ready) gap++;
    end
    prev_v = vany;
    if (resp_valid) begin
      chk("resp_ready_low", {31'd0, req_ready}, 0);
      chk("resp_pulse", {31'd0, prev_resp}, 0);
      chk("resp_expected", {31'd0, sb.size() != 0}, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, e.rdata});
        chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
        if (e.lat != 0) chk("latency", cyc - e.acc + 1, e.lat);
      end
      last_gap = gap;
      gap = 0;
    end
    prev_resp = resp_valid;
  endtask

  task automatic tick();
    if (req_valid && req_ready && !reset) begin
      push_exp();
      accepted = 1'b1;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_accept(input string tag);
    accepted = 1'b0;
    for (int i = 0; i < 50 && !accepted; i++) tick();
    chk(tag, {31'd0, accepted}, 1);
  endtask

  task automatic send(input logic w, input logic [AB-1:0] a, input logic [DB-1:0] d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    wait_accept("accept");
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    sb.delete();
    last_rdata = '0;
    for (int i = 0; i < n; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_rd_valid", {31'd0, mem_read_valid}, 0);
    chk("rst_wr_valid", {31'd0, mem_write_valid}, 0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_resp_error", {31'd0, resp_error}, 0);
    chk("rst_resp_rdata", {16'd0, resp_rdata}, 0);
    reset = 1'b0;
    tick();

    // fastest responder: ack in first wait cycle, release at once
    delay = 0; hold = 0; exp_lat = 4;
    send(1'b0, 8'h05, '0);
    wait_done("fast_done");
    chk("fast_release_gap", last_gap, 1);
    exp_lat = 0;

    // read 0x2A, memory answers after 3 cycles
    delay = 3;
    send(1'b0, 8'h2A, '0);
    wait_done("rd2a_done");
    chk("rd2a_valid_len", last_vrun, 4);

    // write 0x10 <= 0x1234, rdata must keep 0xBEEF
    delay = 2;
    send(1'b1, 8'h10, 16'h1234);
    wait_done("wr10_done");
    chk("wr10_valid_len", last_vrun, 3);
    chk("wr10_mem", {16'd0, mem[8'h10]}, 32'h1234);
    chk("wr10_rdata_held", {16'd0, resp_rdata}, 32'hBEEF);

    // read back the written location
    delay = 1;
    send(1'b0, 8'h10, '0);
    wait_done("rd10_done");

    // responder holds ready for 5 cycles after valid drops
    delay = 0; hold = 5;
    send(1'b0, 8'h33, '0);
    wait_done("hold_done");
    chk("hold_release_gap", last_gap, 6);
    hold = 0;

    // reset in the middle of a read wait
    never = 1'b1;
    send(1'b0, 8'h44, '0);
    tick(); tick();
    chk("mid_rd_valid", {31'd0, mem_read_valid}, 1);
    reset = 1'b1;
    sb.delete();
    last_rdata = '0;
    tick();
    chk("mid_rst_rd_valid", {31'd0, mem_read_valid}, 0);
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 0);
    reset = 1'b0;
    never = 1'b0;
    tick();
    chk("mid_rst_req_ready", {31'd0, req_ready}, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("mid_rst_no_resp", {31'd0, resp_valid}, 0);

    // req_valid held high across a read followed by a write
    delay = 1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h2A; req_wdata = '0;
    wait_accept("b2b_first");
    req_write = 1'b1; req_addr = 8'h20; req_wdata = 16'hCAFE;
    wait_accept("b2b_second");
    req_valid = 1'b0;
    wait_done("b2b_done");
    chk("b2b_mem", {16'd0, mem[8'h20]}, 32'hCAFE);
    chk("b2b_rdata_held", {16'd0, resp_rdata}, 32'hBEEF);

    // memory never acknowledges
    never = 1'b1;
    send(1'b0, 8'h55, '0);
    if (TO_EN) begin
      wait_done("to_done");
      chk("to_valid_len", last_vrun, 15);
      never = 1'b0;
    end else begin
      for (int i = 0; i < 40; i++) tick();
      chk("noto_valid_held", {31'd0, mem_read_valid}, 1);
      chk("noto_pending", sb.size(), 1);
      never = 1'b0;
      do_reset(2);
      tick();
    end

    // a normal write after the stall
    delay = 0;
    send(1'b1, 8'h60, 16'h0F0F);
    wait_done("final_done");
    chk("final_mem", {16'd0, mem[8'h60]}, 32'h0F0F);
    tick();
    chk("final_idle", {31'd0, req_ready}, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_requester.md
MEM_REQUESTER -- requirements
Module: mem_requester

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, memory data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, wait-state cycle limit (used only with MEM_REQ_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  1  core requests a memory transaction.
REQ-007 req_write  input  1  1 = write, 0 = read; sampled with req_valid.
REQ-008 req_addr  input  ADDR_BITS  transaction address.
REQ-009 req_wdata  input  DATA_BITS  write data.
REQ-010 req_ready  output  1  high only in IDLE; request accepted when req_valid && req_ready.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  DATA_BITS  read data, valid with resp_valid; held until next completion.
REQ-013 resp_error  output  1  timeout flag, valid with resp_valid.
REQ-014 mem_read_valid / mem_read_address  output  1 / ADDR_BITS  read request to memory.
REQ-015 mem_read_ready / mem_read_data  input  1 / DATA_BITS  memory read acknowledge and data.
REQ-016 mem_write_valid / mem_write_address / mem_write_data  output  1 / ADDR_BITS / DATA_BITS  write request.
REQ-017 mem_write_ready  input  1  memory write acknowledge.

Function
REQ-018 SHALL implement states IDLE, READ_WAIT, WRITE_WAIT, RELEASE, DONE; all outputs registered.
REQ-019 IDLE: on accept, latch addr/wdata/write; next cycle enter READ_WAIT or WRITE_WAIT with matching mem_*_valid=1.
REQ-020 mem_*_address and mem_write_data SHALL hold stable while the corresponding valid is high.
REQ-021 mem_read_valid and mem_write_valid SHALL never be high in the same cycle.
REQ-022 READ_WAIT: on mem_read_ready sampled 1, capture mem_read_data into resp_rdata, drop mem_read_valid next cycle, enter RELEASE.
REQ-023 WRITE_WAIT: on mem_write_ready sampled 1, drop mem_write_valid next cycle, enter RELEASE; resp_rdata unchanged.
REQ-024 RELEASE: all mem valids low; stay until the relevant mem_*_ready samples 0, then enter DONE.
REQ-025 DONE: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
REQ-026 req_valid outside IDLE SHALL be ignored; no queuing.
REQ-027 Minimum accept-to-resp_valid latency SHALL be 4 cycles with a responder that acknowledges in the first wait cycle and releases immediately.

Reset
REQ-028 reset SHALL force IDLE next edge, including mid-transaction; mem_read_valid, mem_write_valid, resp_valid, resp_error = 0; resp_rdata = 0; req_ready = 1 after reset deasserts.
REQ-029 Timeout counter SHALL clear on reset and on every wait-state entry.

Configuration
REQ-030 Macro MEM_REQ_TIMEOUT_EN defined: counter increments each wait-state cycle without ready; at TIMEOUT_CYCLES, drop valid, set resp_rdata=0, enter RELEASE, report resp_valid with resp_error=1.
REQ-031 Macro MEM_REQ_TIMEOUT_EN undefined: wait states wait indefinitely; resp_error tied 0; no counter logic.

Verification
REQ-032 Read addr 8'h2A, memory returns 16'hBEEF after 3 cycles -> mem_read_valid high until ready seen, resp_valid 1 cycle, resp_rdata=16'hBEEF, resp_error=0.
REQ-033 Write addr 8'h10 data 16'h1234 -> mem_write_valid with stable addr/data until ready, memory[8'h10]=16'h1234, resp_valid 1 cycle, resp_rdata unchanged.
REQ-034 Responder holds ready 5 cycles after valid drops -> stays RELEASE, req_ready=0, resp_valid only after ready low.
REQ-035 reset asserted during READ_WAIT -> next cycle mem_read_valid=0, req_ready=1 after deassert, no resp_valid.
REQ-036 MEM_REQ_TIMEOUT_EN, memory never acknowledges -> valid drops after 15 wait cycles, resp_valid=1, resp_error=1, resp_rdata=0; undefined -> valid held, no response.
REQ-037 req_valid held high continuously across back-to-back read then write -> second accepted only in IDLE after DONE, never both mem valids high.
